adc_sample_scheduler: RTL and testbench
=======================================

# adc_sample_scheduler

Sequencer for the 12-bit I2C ADC master on the power-estimator path. Issues one single-sample read per programmable period, keeps the master's `stop` request high so every transaction ends in NACK/STOP, and detects hung or NACKed transactions by timeout. Accepted samples are forwarded to the HPS as raw values and as a boxcar average over 2^AVG_LOG2 samples.

## Interface
Parameters:
- SAMPLE_PERIOD, default 1000: clocks from one `i2c_start` pulse to the next; legal range ≥ 64.
- TIMEOUT, default 48: clocks allowed from `i2c_start` to `i2c_data_valid`; legal range 40 to SAMPLE_PERIOD−8.
- AVG_LOG2, default 4: log2 of the averaging window; legal range 0 to 8.

Ports:
- clk, in, 1: single clock, same edge domain as the I2C master's `clk`.
- reset, in, 1: asynchronous, active-high.
- enable, in, 1: level; when high, sampling runs.
- i2c_start, out, 1: one-cycle start pulse to the master.
- i2c_stop, out, 1: stop request to the master.
- i2c_data, in, 12: master `data_out`.
- i2c_data_valid, in, 1: master `data_valid`.
- sample_out, out, 12: last accepted raw sample.
- sample_valid, out, 1: one-cycle pulse when `sample_out` updates.
- avg_out, out, 12: window average.
- avg_valid, out, 1: one-cycle pulse when `avg_out` updates.
- busy, out, 1: a transaction is outstanding.
- timeout_cnt, out, 8: saturating count of timed-out transactions.

## Operation
- States: IDLE, ISSUE, WAIT_DATA, GAP.
- IDLE: if `enable` is high, go to ISSUE.
- ISSUE: drive `i2c_start`=1 for exactly this cycle, clear the period counter and the timeout counter, then go to WAIT_DATA.
- WAIT_DATA: `busy`=1. The period counter and timeout counter both increment.
  - On `i2c_data_valid`: latch `i2c_data` into `sample_out`, pulse `sample_valid` next cycle, feed the averager, go to GAP.
  - Else, if the timeout counter reaches TIMEOUT: increment `timeout_cnt` (saturates at 255), discard, go to GAP.
  - If `i2c_data_valid` and timeout expiry occur in the same cycle, data wins and `timeout_cnt` is not incremented.
- GAP: the period counter continues. When it reaches SAMPLE_PERIOD−1:
  - `enable` high → ISSUE.
  - `enable` low → IDLE.
- `i2c_stop` is held at 1 in every state. The master always NACKs after the first 12-bit sample and never enters a continuous read.
- Dropping `enable` mid-transaction does not abort it. WAIT_DATA completes (data or timeout), and GAP then exits to IDLE.
- Averager:
  - Accumulator is 12+AVG_LOG2 bits, unsigned, and cannot overflow.
  - Window counter is AVG_LOG2 bits.
  - On the sample that completes the window, `avg_out` = (acc+sample) >> AVG_LOG2 (truncating), `avg_valid` pulses, and acc clears.
  - Timed-out transactions do not advance the window.
  - AVG_LOG2=0: `avg_out` equals each sample, and `avg_valid` coincides with `sample_valid`.

## Timing
- Reset values: state IDLE; `i2c_start`=0, `i2c_stop`=1; `sample_out`=0, `sample_valid`=0, `avg_out`=0, `avg_valid`=0; `busy`=0, `timeout_cnt`=0; accumulator and window counter 0.
- `enable` rise to first `i2c_start`: 2 cycles (IDLE→ISSUE registered).
- `i2c_start` pulse-to-pulse spacing is exactly SAMPLE_PERIOD cycles while `enable` stays high, independent of data/timeout outcome.
- `i2c_data_valid` is sampled on the same edge the master uses. It is a single-cycle level. `sample_valid` follows 1 cycle after capture; `avg_valid` is asserted in the same cycle as `sample_valid`.
- `i2c_data_valid` outside WAIT_DATA is ignored.
- All outputs are registered. No combinational path from inputs to outputs.
- Reset asserted mid-transaction returns to the reset values immediately. The master is reset by the same signal.

## Structure
- Package `adc_sched_pkg`: state enum `sched_state_t`, `ADC_WIDTH`=12, `TIMEOUT_CNT_W`=8.
- One sub-module, `sample_averager` (accumulator, window counter, divide-by-shift, `avg_valid`), parameterised by AVG_LOG2.
- Top contains the FSM, period counter, timeout counter and output registers.

## Test plan
Bench parameters: SAMPLE_PERIOD=64, TIMEOUT=48, AVG_LOG2=2; master modelled by a responder.

- Enable high, responder returns 0x123 at 35 cycles after each start → `i2c_start` pulses every 64 cycles; `sample_out`=0x123 with `sample_valid` 1 cycle after each `data_valid`; `i2c_stop` constant 1.
- Samples 0x100, 0x101, 0x102, 0x105 → one `avg_valid` after the 4th sample, `avg_out`=0x102 (0x408>>2).
- Responder never answers → `timeout_cnt` increments once per period (1, 2, 3); no `sample_valid`; start spacing stays 64. After 300 timeouts, `timeout_cnt` holds 255.
- `data_valid` on exactly cycle 48 after start → sample accepted, `timeout_cnt` unchanged.
- Enable dropped 10 cycles after start → transaction completes, `sample_valid` pulses, no further `i2c_start`; FSM returns to IDLE.
- Reset asserted in WAIT_DATA → all outputs at reset values immediately; after release, first `i2c_start` 2 cycles after enable is seen high.

Source files
------------

// File: rtl/adc_sched_pkg.sv
// Shared definitions for the ADC sample scheduler.
// Contents:
//   ADC_WIDTH      - width of one I2C ADC sample
//   TIMEOUT_CNT_W  - width of the saturating timeout counter
//   sched_state_t  - scheduler FSM states
//   sat_inc        - saturating increment for the timeout counter
package adc_sched_pkg;

    localparam int ADC_WIDTH     = 12;
    localparam int TIMEOUT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2,
        GAP       = 2'd3
    } sched_state_t;

    // Count up but stick at all-ones so a long outage never wraps to a small value
    function automatic logic [TIMEOUT_CNT_W-1:0] sat_inc(input logic [TIMEOUT_CNT_W-1:0] value);
        return (value == '1) ? value : value + TIMEOUT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sample_averager.sv
// Boxcar averager over 2^AVG_LOG2 accepted samples.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   sample_en   - one-cycle strobe: `sample` is an accepted ADC reading
//   sample      - raw ADC reading
//   avg_out     - registered window average (truncating)
//   avg_valid   - one-cycle pulse when avg_out updates
module sample_averager
    import adc_sched_pkg::*;
#(
    parameter int AVG_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic [ADC_WIDTH-1:0] sample,
    output logic [ADC_WIDTH-1:0] avg_out,
    output logic                 avg_valid
);

    generate
        if (AVG_LOG2 == 0) begin : g_passthru
            // A window of one sample is the sample itself
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    avg_out   <= '0;
                    avg_valid <= 1'b0;
                end else begin
                    avg_valid <= sample_en;
                    if (sample_en) begin
                        avg_out <= sample;
                    end
                end
            end
        end else begin : g_window
            // Accumulator is wide enough for a full window of maximum samples
            localparam int ACC_W = ADC_WIDTH + AVG_LOG2;

            logic [ACC_W-1:0]    acc;
            logic [ACC_W-1:0]    sum;
            logic [AVG_LOG2-1:0] win_cnt;

            assign sum = acc + ACC_W'(sample);

            // The window counter wraps naturally; all-ones marks the closing sample,
            // whose sum is divided by shifting and the accumulator restarts at zero
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    acc       <= '0;
                    win_cnt   <= '0;
                    avg_out   <= '0;
                    avg_valid <= 1'b0;
                end else begin
                    avg_valid <= 1'b0;
                    if (sample_en) begin
                        win_cnt <= win_cnt + AVG_LOG2'(1);
                        if (win_cnt == '1) begin
                            avg_out   <= sum[ACC_W-1:AVG_LOG2];
                            avg_valid <= 1'b1;
                            acc       <= '0;
                        end else begin
                            acc <= sum;
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/adc_sample_scheduler.sv
// Sequencer for the 12-bit I2C ADC master: one single-sample read per
// SAMPLE_PERIOD clocks, hung/NACKed reads detected by TIMEOUT, accepted
// samples forwarded raw and as a 2^AVG_LOG2 boxcar average.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   enable          - level; sampling runs while high
//   i2c_start       - one-cycle start pulse to the master
//   i2c_stop        - stop request, held high so every read ends in NACK/STOP
//   i2c_data        - master data_out
//   i2c_data_valid  - master data_valid (single-cycle)
//   sample_out      - last accepted raw sample
//   sample_valid    - one-cycle pulse when sample_out updates
//   avg_out         - window average
//   avg_valid       - one-cycle pulse when avg_out updates
//   busy            - a read is outstanding
//   timeout_cnt     - saturating count of timed-out reads
module adc_sample_scheduler
    import adc_sched_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 1000,
    parameter int TIMEOUT       = 48,
    parameter int AVG_LOG2      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    output logic                     i2c_start,
    output logic                     i2c_stop,
    input  logic [ADC_WIDTH-1:0]     i2c_data,
    input  logic                     i2c_data_valid,
    output logic [ADC_WIDTH-1:0]     sample_out,
    output logic                     sample_valid,
    output logic [ADC_WIDTH-1:0]     avg_out,
    output logic                     avg_valid,
    output logic                     busy,
    output logic [TIMEOUT_CNT_W-1:0] timeout_cnt
);

    localparam int PER_W = $clog2(SAMPLE_PERIOD);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    sched_state_t     state;
    sched_state_t     next_state;
    logic [PER_W-1:0] period_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             capture;
    logic             expire;
    logic             period_done;

    assign period_done = (period_cnt == PER_W'(SAMPLE_PERIOD - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; data arriving on the expiry cycle still wins over the timeout
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (i2c_data_valid) begin
                    capture    = 1'b1;
                    next_state = GAP;
                end else if (to_cnt == TO_W'(TIMEOUT)) begin
                    expire     = 1'b1;
                    next_state = GAP;
                end
            end
            GAP: begin
                if (period_done) begin
                    next_state = enable ? ISSUE : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The ISSUE cycle is cycle 0 of the period, so the counter restarts at 1 and
    // GAP ends on SAMPLE_PERIOD-1, which puts consecutive ISSUEs exactly one period apart.
    // The timeout counter equals the number of cycles since i2c_start was seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_cnt <= '0;
            to_cnt     <= '0;
        end else begin
            case (state)
                ISSUE: begin
                    period_cnt <= PER_W'(1);
                    to_cnt     <= '0;
                end
                WAIT_DATA: begin
                    period_cnt <= period_cnt + PER_W'(1);
                    to_cnt     <= to_cnt + TO_W'(1);
                end
                GAP: begin
                    if (!period_done) begin
                        period_cnt <= period_cnt + PER_W'(1);
                    end
                end
                default: begin
                    period_cnt <= period_cnt;
                end
            endcase
        end
    end

    // Registered outputs; i2c_start follows the ISSUE cycle so it lands on the
    // first WAIT_DATA cycle, where the timeout count starts from zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i2c_start    <= 1'b0;
            i2c_stop     <= 1'b1;
            busy         <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            timeout_cnt  <= '0;
        end else begin
            i2c_start    <= (state == ISSUE);
            i2c_stop     <= 1'b1;
            busy         <= (next_state == WAIT_DATA);
            sample_valid <= capture;
            if (capture) begin
                sample_out <= i2c_data;
            end
            if (expire) begin
                timeout_cnt <= sat_inc(timeout_cnt);
            end
        end
    end

    sample_averager #(
        .AVG_LOG2(AVG_LOG2)
    ) u_averager (
        .clk      (clk),
        .reset    (reset),
        .sample_en(capture),
        .sample   (i2c_data),
        .avg_out  (avg_out),
        .avg_valid(avg_valid)
    );

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Testbench for adc_sample_scheduler: an I2C master responder plus a
// transaction-level reference model of start times, accepted samples,
// window averages, busy windows and timeout counts.
module tb_adc_sample_scheduler;

    localparam int SAMPLE_PERIOD = 64;
    localparam int TIMEOUT       = 48;
    localparam int AVG_LOG2      = 2;
    localparam int WINDOW        = 1 << AVG_LOG2;
    localparam int SPUR_OFFSET   = 58;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        i2c_start;
    logic        i2c_stop;
    logic [11:0] i2c_data;
    logic        i2c_data_valid;
    logic [11:0] sample_out;
    logic        sample_valid;
    logic [11:0] avg_out;
    logic        avg_valid;
    logic        busy;
    logic [7:0]  timeout_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Stimulus controls
    bit          rst_next    = 1'b1;
    bit          en_next     = 1'b0;
    int          resp_delay  = 35;
    bit          resp_random = 1'b0;
    bit          spurious    = 1'b0;
    logic [11:0] data_q[$];

    // Reference model state
    bit          idle;
    int          exp_start, last_start;
    int          dv_cycle, spur_cycle, accept_cycle, to_cycle, busy_lo, busy_hi;
    bit          dv_accept;
    logic [11:0] dv_data, acc_data;
    bit          exp_start_now, exp_sv_now, exp_av_now, exp_busy_now;
    logic [11:0] exp_sample, exp_avg;
    int          exp_to, win_sum, win_n;

    adc_sample_scheduler #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD),
        .TIMEOUT      (TIMEOUT),
        .AVG_LOG2     (AVG_LOG2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .i2c_start     (i2c_start),
        .i2c_stop      (i2c_stop),
        .i2c_data      (i2c_data),
        .i2c_data_valid(i2c_data_valid),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .avg_out       (avg_out),
        .avg_valid     (avg_valid),
        .busy          (busy),
        .timeout_cnt   (timeout_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, limit 2000000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_clear();
        idle         = 1'b1;
        exp_start    = -1;
        last_start   = -1;
        dv_cycle     = -1;
        spur_cycle   = -1;
        accept_cycle = -2;
        to_cycle     = -1;
        busy_lo      = -1;
        busy_hi      = -2;
        dv_accept    = 1'b0;
        exp_sample   = '0;
        exp_avg      = '0;
        exp_to       = 0;
        win_sum      = 0;
        win_n        = 0;
    endtask

    // Advance one cycle: outputs are then stable for cycle 'cyc', the model
    // produces this cycle's expectations and the inputs for this cycle are driven
    task automatic tick();
        int d;
        @(posedge clk);
        #1;
        cyc++;
        exp_start_now = (cyc == exp_start);
        if (exp_start_now) begin
            last_start = cyc;
            exp_start  = -1;
        end
        exp_sv_now = 1'b0;
        exp_av_now = 1'b0;
        if (cyc == accept_cycle + 1) begin
            exp_sv_now = 1'b1;
            exp_sample = acc_data;
            win_sum    = win_sum + int'(acc_data);
            win_n      = win_n + 1;
            if (win_n == WINDOW) begin
                exp_av_now = 1'b1;
                exp_avg    = 12'(win_sum / WINDOW);
                win_sum    = 0;
                win_n      = 0;
            end
        end
        if (cyc == to_cycle && exp_to < 255) begin
            exp_to = exp_to + 1;
        end
        reset          = rst_next;
        enable         = en_next;
        i2c_data_valid = 1'b0;
        if (rst_next) begin
            model_clear();
        end else begin
            if (i2c_start === 1'b1) begin
                d = resp_random ? int'($urandom_range(1, 56)) : resp_delay;
                if (data_q.size() > 0) begin
                    dv_data = data_q.pop_front();
                end else begin
                    dv_data = 12'($urandom_range(0, 4095));
                end
                dv_accept  = (d >= 0 && d <= TIMEOUT);
                dv_cycle   = (d >= 0) ? cyc + d : -1;
                busy_lo    = cyc;
                busy_hi    = dv_accept ? cyc + d : cyc + TIMEOUT;
                to_cycle   = dv_accept ? -1 : cyc + TIMEOUT + 1;
                spur_cycle = spurious ? cyc + SPUR_OFFSET : -1;
            end
            if (cyc == dv_cycle) begin
                i2c_data_valid = 1'b1;
                i2c_data       = dv_data;
                if (dv_accept) begin
                    accept_cycle = cyc;
                    acc_data     = dv_data;
                end
            end else if (cyc == spur_cycle) begin
                i2c_data_valid = 1'b1;
                i2c_data       = 12'($urandom_range(0, 4095));
            end
            if (idle) begin
                if (enable) begin
                    exp_start = cyc + 2;
                    idle      = 1'b0;
                end
            end else if (exp_start < 0 && last_start >= 0 && cyc == last_start + SAMPLE_PERIOD - 2) begin
                if (enable) begin
                    exp_start = last_start + SAMPLE_PERIOD;
                end else begin
                    idle = 1'b1;
                end
            end
        end
        exp_busy_now = (cyc >= busy_lo && cyc <= busy_hi);
    endtask

    task automatic test_reset();
        rst_next = 1'b1;
        en_next  = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({i2c_start, i2c_stop, sample_valid, avg_valid, busy, timeout_cnt, sample_out, avg_out} !==
            {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 12'd0, 12'd0}) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got start=%b stop=%b sv=%b av=%b busy=%b tcnt=%0d sample=%h avg=%h, expected 0 1 0 0 0 0 000 000",
                     i2c_start, i2c_stop, sample_valid, avg_valid, busy, timeout_cnt, sample_out, avg_out);
        end
        rst_next = 1'b0;
        repeat (4) begin
            tick();
            vectors++;
            if (i2c_start !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL idle_quiet: got start=%b busy=%b expected 0 0", i2c_start, busy);
            end
        end
    endtask

    task automatic test_average();
        int av_pulses = 0;
        data_q.delete();
        data_q.push_back(12'h100);
        data_q.push_back(12'h101);
        data_q.push_back(12'h102);
        data_q.push_back(12'h105);
        resp_delay = 35;
        en_next    = 1'b1;
        repeat (4 * SAMPLE_PERIOD + 8) begin
            tick();
            vectors++;
            if (avg_valid !== exp_av_now) begin
                miscompares++;
                $display("[TB] FAIL avg_valid: cycle %0d got %b expected %b", cyc, avg_valid, exp_av_now);
            end
            if (avg_valid === 1'b1) av_pulses++;
            if (exp_av_now) begin
                vectors++;
                if (avg_out !== exp_avg) begin
                    miscompares++;
                    $display("[TB] FAIL avg_out: cycle %0d got %h expected %h", cyc, avg_out, exp_avg);
                end
            end
        end
        vectors++;
        if (avg_out !== 12'h102) begin
            miscompares++;
            $display("[TB] FAIL avg_first_window: got %h expected 102", avg_out);
        end
        vectors++;
        if (av_pulses != 1) begin
            miscompares++;
            $display("[TB] FAIL avg_pulse_count: got %0d expected 1", av_pulses);
        end
    endtask

    task automatic test_periodic();
        int prev = -1;
        repeat (8) data_q.push_back(12'h123);
        resp_delay = 35;
        repeat (6 * SAMPLE_PERIOD) begin
            tick();
            vectors++;
            if (i2c_start !== exp_start_now) begin
                miscompares++;
                $display("[TB] FAIL start_timing: cycle %0d got %b expected %b", cyc, i2c_start, exp_start_now);
            end
            if (i2c_start === 1'b1) begin
                if (prev >= 0) begin
                    vectors++;
                    if (cyc - prev != SAMPLE_PERIOD) begin
                        miscompares++;
                        $display("[TB] FAIL start_spacing: got %0d expected %0d", cyc - prev, SAMPLE_PERIOD);
                    end
                end
                prev = cyc;
            end
            vectors++;
            if (i2c_stop !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL stop_held: cycle %0d got %b expected 1", cyc, i2c_stop);
            end
            vectors++;
            if (sample_valid !== exp_sv_now) begin
                miscompares++;
                $display("[TB] FAIL sample_valid: cycle %0d got %b expected %b", cyc, sample_valid, exp_sv_now);
            end
            if (exp_sv_now) begin
                vectors++;
                if (sample_out !== exp_sample) begin
                    miscompares++;
                    $display("[TB] FAIL sample_out: cycle %0d got %h expected %h", cyc, sample_out, exp_sample);
                end
            end
        end
        vectors++;
        if (sample_out !== 12'h123) begin
            miscompares++;
            $display("[TB] FAIL periodic_value: got %h expected 123", sample_out);
        end
    endtask

    task automatic test_random();
        resp_random = 1'b1;
        spurious    = 1'b1;
        repeat (40 * SAMPLE_PERIOD) begin
            tick();
            vectors++;
            if (i2c_start !== exp_start_now || sample_valid !== exp_sv_now || avg_valid !== exp_av_now ||
                busy !== exp_busy_now || timeout_cnt !== 8'(exp_to)) begin
                miscompares++;
                $display("[TB] FAIL random_ctrl: cycle %0d got start=%b sv=%b av=%b busy=%b tcnt=%0d expected %b %b %b %b %0d",
                         cyc, i2c_start, sample_valid, avg_valid, busy, timeout_cnt,
                         exp_start_now, exp_sv_now, exp_av_now, exp_busy_now, exp_to);
            end
            if (exp_sv_now) begin
                vectors++;
                if (sample_out !== exp_sample) begin
                    miscompares++;
                    $display("[TB] FAIL random_sample: cycle %0d got %h expected %h", cyc, sample_out, exp_sample);
                end
            end
            if (exp_av_now) begin
                vectors++;
                if (avg_out !== exp_avg) begin
                    miscompares++;
                    $display("[TB] FAIL random_avg: cycle %0d got %h expected %h", cyc, avg_out, exp_avg);
                end
            end
        end
        resp_random = 1'b0;
        spurious    = 1'b0;
    endtask

    task automatic test_timeout_boundary();
        int n;
        int to_before;
        int sv_count;
        resp_delay = TIMEOUT;
        data_q.delete();
        data_q.push_back(12'hABC);
        n = 0;
        do begin tick(); n++; end while (i2c_start !== 1'b1 && n < 2 * SAMPLE_PERIOD);
        vectors++;
        if (i2c_start !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL boundary_wait_start: got %b expected 1", i2c_start);
        end
        to_before = exp_to;
        resp_delay = TIMEOUT + 1;
        sv_count = 0;
        repeat (SAMPLE_PERIOD - 1) begin
            tick();
            if (sample_valid === 1'b1) sv_count++;
        end
        vectors++;
        if (sv_count != 1 || sample_out !== 12'hABC || timeout_cnt !== 8'(to_before)) begin
            miscompares++;
            $display("[TB] FAIL boundary_accept: got sv=%0d sample=%h tcnt=%0d expected 1 abc %0d",
                     sv_count, sample_out, timeout_cnt, to_before);
        end
        tick();
        vectors++;
        if (i2c_start !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL boundary_next_start: got %b expected 1", i2c_start);
        end
        sv_count = 0;
        repeat (SAMPLE_PERIOD - 1) begin
            tick();
            if (sample_valid === 1'b1) sv_count++;
        end
        vectors++;
        if (sv_count != 0 || timeout_cnt !== 8'(to_before + 1)) begin
            miscompares++;
            $display("[TB] FAIL boundary_late: got sv=%0d tcnt=%0d expected 0 %0d", sv_count, timeout_cnt, to_before + 1);
        end
    endtask

    task automatic test_timeouts();
        int n;
        int base;
        resp_delay = -1;
        n = 0;
        do begin tick(); n++; end while (i2c_start !== 1'b1 && n < 2 * SAMPLE_PERIOD);
        base = exp_to;
        for (int k = 1; k <= 3; k++) begin
            repeat (SAMPLE_PERIOD) begin
                tick();
                vectors++;
                if (sample_valid !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL timeout_no_sample: cycle %0d got %b expected 0", cyc, sample_valid);
                end
            end
            vectors++;
            if (timeout_cnt !== 8'(base + k) || i2c_start !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL timeout_step: got tcnt=%0d start=%b expected %0d 1", timeout_cnt, i2c_start, base + k);
            end
        end
        repeat (297 * SAMPLE_PERIOD) begin
            tick();
            vectors++;
            if (timeout_cnt !== 8'(exp_to) || i2c_start !== exp_start_now) begin
                miscompares++;
                $display("[TB] FAIL timeout_run: cycle %0d got tcnt=%0d start=%b expected %0d %b",
                         cyc, timeout_cnt, i2c_start, exp_to, exp_start_now);
            end
        end
        vectors++;
        if (timeout_cnt !== 8'd255) begin
            miscompares++;
            $display("[TB] FAIL timeout_saturate: got %0d expected 255", timeout_cnt);
        end
    endtask

    task automatic test_enable_drop();
        int n;
        int sv_count = 0;
        int starts = 0;
        int rise;
        resp_delay = 35;
        data_q.delete();
        data_q.push_back(12'h5A5);
        n = 0;
        do begin tick(); n++; end while (i2c_start !== 1'b1 && n < 2 * SAMPLE_PERIOD);
        repeat (9) tick();
        en_next = 1'b0;
        repeat (200) begin
            tick();
            if (sample_valid === 1'b1) sv_count++;
            if (i2c_start === 1'b1) starts++;
            vectors++;
            if (busy !== exp_busy_now || i2c_start !== exp_start_now) begin
                miscompares++;
                $display("[TB] FAIL drop_ctrl: cycle %0d got busy=%b start=%b expected %b %b",
                         cyc, busy, i2c_start, exp_busy_now, exp_start_now);
            end
        end
        vectors++;
        if (sv_count != 1 || starts != 0 || busy !== 1'b0 || sample_out !== 12'h5A5) begin
            miscompares++;
            $display("[TB] FAIL drop_complete: got sv=%0d starts=%0d busy=%b sample=%h expected 1 0 0 5a5",
                     sv_count, starts, busy, sample_out);
        end
        en_next = 1'b1;
        tick();
        rise = cyc;
        n = 0;
        do begin tick(); n++; end while (i2c_start !== 1'b1 && n < 8);
        vectors++;
        if (i2c_start !== 1'b1 || cyc - rise != 2) begin
            miscompares++;
            $display("[TB] FAIL drop_reenable_latency: got %0d cycles start=%b expected 2 1", cyc - rise, i2c_start);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int rel;
        resp_delay = 35;
        n = 0;
        do begin tick(); n++; end while (i2c_start !== 1'b1 && n < 2 * SAMPLE_PERIOD);
        repeat (5) tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_busy: got %b expected 1", busy);
        end
        rst_next       = 1'b1;
        reset          = 1'b1;
        i2c_data_valid = 1'b0;
        #1;
        vectors++;
        if ({i2c_start, i2c_stop, sample_valid, avg_valid, busy, timeout_cnt, sample_out, avg_out} !==
            {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 12'd0, 12'd0}) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_values: got start=%b stop=%b sv=%b av=%b busy=%b tcnt=%0d sample=%h avg=%h, expected 0 1 0 0 0 0 000 000",
                     i2c_start, i2c_stop, sample_valid, avg_valid, busy, timeout_cnt, sample_out, avg_out);
        end
        model_clear();
        en_next = 1'b1;
        repeat (3) tick();
        rst_next = 1'b0;
        tick();
        rel = cyc;
        n = 0;
        do begin
            tick();
            n++;
            vectors++;
            if (i2c_start !== exp_start_now) begin
                miscompares++;
                $display("[TB] FAIL mid_restart: cycle %0d got %b expected %b", cyc, i2c_start, exp_start_now);
            end
        end while (i2c_start !== 1'b1 && n < 8);
        vectors++;
        if (i2c_start !== 1'b1 || cyc - rel != 2) begin
            miscompares++;
            $display("[TB] FAIL mid_restart_latency: got %0d cycles start=%b expected 2 1", cyc - rel, i2c_start);
        end
    endtask

    initial begin
        reset          = 1'b1;
        enable         = 1'b0;
        i2c_data       = '0;
        i2c_data_valid = 1'b0;
        model_clear();
        test_reset();
        test_average();
        test_periodic();
        test_random();
        test_timeout_boundary();
        test_timeouts();
        test_enable_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
